// File: rtl/serial_adder.sv
// Bit-serial adder: one full_adder cell, LSB first, WIDTH+2 cycles per addition.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             overflow,
`endif
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sh_a, sh_b, work;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s, fa_co;
    logic             last;

    full_adder u_fa (
        .a  (sh_a[0]),
        .b  (sh_b[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    assign last = (state == RUN) && (cnt == CW'(WIDTH - 1));
    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sh_a      <= '0;
            sh_b      <= '0;
            work      <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            overflow  <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                sh_a  <= a;
                sh_b  <= b;
                carry <= c_in;
                cnt   <= '0;
            end else if (state == RUN) begin
                sh_a  <= sh_a >> 1;
                sh_b  <= sh_b >> 1;
                work  <= {fa_s, work[WIDTH-1:1]};
                carry <= fa_co;
                cnt   <= cnt + 1'b1;
                // Final bit is published straight from the cell so sum never lags a cycle.
                if (last) begin
                    sum       <= {fa_s, work[WIDTH-1:1]};
                    carry_out <= fa_co;
`ifdef SERIAL_ADDER_OVF_EN
                    overflow  <= carry ^ fa_co;
`endif
                end
            end
        end
    end
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and sum width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an addition; sampled only in IDLE.
REQ-005 The block SHALL have port a, input, WIDTH bits: operand A, captured on an accepted start.
REQ-006 The block SHALL have port b, input, WIDTH bits: operand B, captured on an accepted start.
REQ-007 The block SHALL have port c_in, input, 1 bit: carry-in, captured on an accepted start.
REQ-008 The block SHALL have port sum, output, WIDTH bits: registered result of a+b+c_in, modulo 2^WIDTH.
REQ-009 The block SHALL have port carry_out, output, 1 bit: registered carry out of the MSB.
REQ-010 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse when sum and carry_out become valid.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-013 IDLE: on start=1, the block SHALL load a, b into shift registers, load c_in into the carry flop, clear the bit counter and go to RUN; start=0 SHALL keep it in IDLE.
REQ-014 RUN: each cycle, the block SHALL add shift-register LSBs plus the carry flop using one instance of the team's full_adder cell.
  - The sum bit SHALL shift into a working result register from the MSB end.
  - The full_adder carry SHALL be written to the carry flop.
  - The operand registers SHALL shift right by one.
  - The counter SHALL increment.
REQ-015 After exactly WIDTH RUN cycles, the block SHALL go to DONE and copy the working result to sum and the carry flop to carry_out in that same edge.
REQ-016 DONE: done=1 for exactly one cycle, then unconditional return to IDLE.
REQ-017 Latency: for start sampled at edge 0, busy SHALL be high edges 1..WIDTH, and done and the new result SHALL be visible after edge WIDTH+1.
REQ-018 sum and carry_out SHALL hold their last result through IDLE and RUN until the next DONE; they SHALL never show partial results.
REQ-019 start asserted in RUN or DONE SHALL be ignored, with no queuing; changes on a, b, c_in after capture SHALL have no effect.
REQ-020 start held high continuously SHALL begin a new addition on each IDLE cycle, one every WIDTH+2 cycles.
REQ-021 Maximum operands (all ones, c_in=1) SHALL yield sum all ones and carry_out=1, with no extra width.

Reset
REQ-022 rst=1 SHALL, asynchronously and in any state including mid-RUN, force the FSM to IDLE and clear all of the following to 0: busy, done, sum, carry_out, counter, shift registers, carry flop.
REQ-023 After rst deasserts, the first start SHALL be accepted on the first rising edge at which it is sampled high; an addition aborted by reset SHALL produce no done.

Configuration
REQ-024 With macro SERIAL_ADDER_OVF_EN defined, the block SHALL add output port overflow, 1 bit, equal to the two's-complement signed overflow of a+b+c_in. It SHALL be computed as carry into the MSB XOR carry out of the MSB, registered and updated together with sum, and reset to 0.
REQ-025 Without SERIAL_ADDER_OVF_EN, the block SHALL have no overflow port and no associated logic; all other behaviour SHALL be identical.

Verification (WIDTH=8)
REQ-026 The bench SHALL cover: a=0x00, b=0x00, c_in=0, start pulse at edge 0 -> busy high edges 1..8; done pulse after edge 9; sum=0x00, carry_out=0.
REQ-027 The bench SHALL cover: a=0xFF, b=0x01, c_in=0 -> sum=0x00, carry_out=1; a=0xA5, b=0x5A, c_in=1 -> sum=0x00, carry_out=1.
REQ-028 The bench SHALL cover: a=0x12, b=0x34, c_in=0 started, then start re-pulsed at edge 4 with a=0xFF -> single done; sum=0x46; second start ignored.
REQ-029 The bench SHALL cover: prior result sum=0x46 held, new addition started, rst pulsed at edge 5 -> immediately busy=0, sum=0x00, carry_out=0; no done follows.
REQ-030 The bench SHALL cover, with SERIAL_ADDER_OVF_EN: a=0x7F, b=0x01, c_in=0 -> sum=0x80, overflow=1; a=0xFF, b=0x01 -> overflow=0, carry_out=1.
REQ-031 The bench SHALL cover: start held high with a=0x01, b=0x01, c_in=0 -> done pulses every 10 cycles, sum=0x02 each time.
